// File: rtl/codec_i2c_pkg.sv
// Shared definitions for the audio-codec I2C write responder:
// FSM states, default device address and the codec register reset table.
package codec_i2c_pkg;

    typedef enum logic [2:0] {
        IDLE,
        ADDR,
        ACK_A,
        BYTE_HI,
        ACK_HI,
        BYTE_LO,
        ACK_LO,
        IGNORE
    } i2c_state_e;

    localparam logic [6:0] DEF_DEV_ADDR = 7'h1A;
    localparam int         DEF_NUM_REGS = 10;
    localparam logic [6:0] RESET_REG    = 7'h0F;

    // Power-on contents of codec registers R0..R9; anything beyond reads zero.
    function automatic logic [8:0] reg_default(input int idx);
        case (idx)
            0, 1:    return 9'h097;
            2, 3:    return 9'h079;
            4:       return 9'h00A;
            5:       return 9'h008;
            6:       return 9'h09F;
            7:       return 9'h00A;
            default: return 9'h000;
        endcase
    endfunction

endpackage

// File: rtl/i2c_line_sync.sv
// Two-flop synchronizer plus edge detect for one I2C line.
// Define I2C_RESP_GLITCH_FILTER_EN to require 4 stable cycles before a new level is accepted.
module i2c_line_sync (
    input  logic CLOCK_50,
    input  logic rst,
    input  logic din,
    output logic level,
    output logic rise,
    output logic fall
);

    logic [1:0] sync;
    logic       prev;
    logic [2:0] prime_cnt;
    logic       primed;

    always_ff @(posedge CLOCK_50 or negedge rst) begin
        if (!rst) sync <= 2'b11;
        else      sync <= {sync[0], din};
    end

`ifdef I2C_RESP_GLITCH_FILTER_EN
    logic [1:0] stable_cnt;
    logic       filt;

    always_ff @(posedge CLOCK_50 or negedge rst) begin
        if (!rst) begin
            filt       <= 1'b1;
            stable_cnt <= '0;
        end else if (sync[1] == filt) begin
            stable_cnt <= '0;
        end else if (stable_cnt == 2'd3) begin
            filt       <= sync[1];
            stable_cnt <= '0;
        end else begin
            stable_cnt <= stable_cnt + 2'd1;
        end
    end

    assign level = filt;
`else
    assign level = sync[1];
`endif

    // Edges are masked until the pipeline holds real bus samples, so the
    // idle-high reset value cannot masquerade as a START after reset.
    assign primed = (prime_cnt == 3'd7);

    always_ff @(posedge CLOCK_50 or negedge rst) begin
        if (!rst) begin
            prev      <= 1'b1;
            prime_cnt <= '0;
        end else begin
            prev <= level;
            if (!primed) prime_cnt <= prime_cnt + 3'd1;
        end
    end

    assign rise = primed &  level & ~prev;
    assign fall = primed & ~level &  prev;

endmodule

// File: rtl/i2c_codec_responder.sv
// I2C write-only responder emulating an audio codec register file (7-bit reg, 9-bit data).
// Optional glitch filter on the bus lines: define I2C_RESP_GLITCH_FILTER_EN.
module i2c_codec_responder
    import codec_i2c_pkg::*;
#(
    parameter logic [6:0] DEV_ADDR = DEF_DEV_ADDR,
    parameter int         NUM_REGS = DEF_NUM_REGS
) (
    input  logic       CLOCK_50,
    input  logic       rst,
    input  logic       I2C_SCLK,
    inout  wire        I2C_SDAT,
    output logic       wr_strobe,
    output logic [6:0] wr_reg,
    output logic [8:0] wr_data,
    input  logic [3:0] dbg_addr,
    output logic [8:0] dbg_data,
    output logic [3:0] bad_count
);

    logic scl_lvl, scl_rise, scl_fall;
    logic sda_lvl, sda_rise, sda_fall;

    i2c_line_sync u_scl (.CLOCK_50(CLOCK_50), .rst(rst), .din(I2C_SCLK),
                         .level(scl_lvl), .rise(scl_rise), .fall(scl_fall));
    i2c_line_sync u_sda (.CLOCK_50(CLOCK_50), .rst(rst), .din(I2C_SDAT),
                         .level(sda_lvl), .rise(sda_rise), .fall(sda_fall));

    i2c_state_e state, nxt;
    logic [3:0] bit_cnt;
    logic [7:0] shreg, hi_byte;
    logic       done;
    logic [8:0] regs [NUM_REGS];

    logic start_c, stop_c, incomplete;
    logic shift, clr_cnt, latch_hi, commit, bad_inc, set_done, clr_done;
    logic [6:0] w_reg;
    logic [8:0] w_data;

    assign start_c = sda_fall & scl_lvl;
    assign stop_c  = sda_rise & scl_lvl;
    assign w_reg   = hi_byte[7:1];
    assign w_data  = {hi_byte[0], shreg[6:0], sda_lvl};

    // A STOP's own SCL rise clocks one bit, so a lone bit in BYTE_HI is not a started word.
    assign incomplete = (state == ACK_HI) || (state == BYTE_LO) ||
                        (state == BYTE_HI && !done && bit_cnt >= 4'd2);

    assign I2C_SDAT = (state == ACK_A || state == ACK_HI || state == ACK_LO) ? 1'b0 : 1'bz;

    always_ff @(posedge CLOCK_50 or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= nxt;
    end

    always_comb begin
        nxt      = state;
        shift    = 1'b0;
        clr_cnt  = 1'b0;
        latch_hi = 1'b0;
        commit   = 1'b0;
        bad_inc  = 1'b0;
        set_done = 1'b0;
        clr_done = 1'b0;
        if (start_c) begin
            nxt      = ADDR;
            clr_cnt  = 1'b1;
            clr_done = 1'b1;
        end else if (stop_c) begin
            nxt     = IDLE;
            bad_inc = incomplete;
        end else begin
            case (state)
                ADDR, BYTE_HI, BYTE_LO: begin
                    if (scl_rise && bit_cnt < 4'd8) shift = 1'b1;
                    if (state == BYTE_LO && scl_rise && bit_cnt == 4'd7) begin
                        if (w_reg == RESET_REG || int'(w_reg) < NUM_REGS) commit  = 1'b1;
                        else                                              bad_inc = 1'b1;
                    end
                    if (scl_fall && bit_cnt == 4'd8) begin
                        clr_cnt = 1'b1;
                        if (state == ADDR) begin
                            nxt = (shreg == {DEV_ADDR, 1'b0}) ? ACK_A : IGNORE;
                        end else if (state == BYTE_HI) begin
                            if (done) begin
                                nxt     = IGNORE;
                                bad_inc = 1'b1;
                            end else begin
                                nxt      = ACK_HI;
                                latch_hi = 1'b1;
                            end
                        end else begin
                            nxt = ACK_LO;
                        end
                    end
                end
                ACK_A:  if (scl_fall) begin nxt = BYTE_HI; clr_cnt = 1'b1; end
                ACK_HI: if (scl_fall) begin nxt = BYTE_LO; clr_cnt = 1'b1; end
                ACK_LO: if (scl_fall) begin nxt = BYTE_HI; clr_cnt = 1'b1; set_done = 1'b1; end
                default: ;
            endcase
        end
    end

    always_ff @(posedge CLOCK_50 or negedge rst) begin
        if (!rst) begin
            bit_cnt   <= '0;
            shreg     <= '0;
            hi_byte   <= '0;
            done      <= 1'b0;
            wr_strobe <= 1'b0;
            wr_reg    <= '0;
            wr_data   <= '0;
            bad_count <= '0;
            for (int i = 0; i < NUM_REGS; i++) regs[i] <= reg_default(i);
        end else begin
            wr_strobe <= commit;
            if (clr_cnt) begin
                bit_cnt <= '0;
            end else if (shift) begin
                bit_cnt <= bit_cnt + 4'd1;
                shreg   <= {shreg[6:0], sda_lvl};
            end
            if (latch_hi) hi_byte <= shreg;
            if (clr_done)      done <= 1'b0;
            else if (set_done) done <= 1'b1;
            if (bad_inc && bad_count != 4'hF) bad_count <= bad_count + 4'd1;
            if (commit) begin
                wr_reg  <= w_reg;
                wr_data <= w_data;
                for (int i = 0; i < NUM_REGS; i++) begin
                    if (w_reg == RESET_REG)    regs[i] <= reg_default(i);
                    else if (int'(w_reg) == i) regs[i] <= w_data;
                end
            end
        end
    end

    always_comb begin
        dbg_data = '0;
        for (int i = 0; i < NUM_REGS; i++)
            if (int'(dbg_addr) == i) dbg_data = regs[i];
    end

endmodule
